// File: rtl/pa_noc.sv
// -----------------------------------------------------------------------------
// pa_noc : shared definitions for the NoC APB network interface.
//   - APB address/data widths and mesh coordinate width
//   - request/response packet width, field offsets and packed layout
//   - APB address bits carrying the destination row/column
// -----------------------------------------------------------------------------
package pa_noc;

   localparam int APB_ADDR_W       = 32;
   localparam int APB_DATA_W       = 32;
   localparam int COORD_W          = 2;
   localparam int APB_PACKET_WIDTH = 76;

   // Field offsets inside a packet (LSB positions / single-bit positions)
   localparam int PKT_DST_COL_LSB = 0;
   localparam int PKT_DST_ROW_LSB = 2;
   localparam int PKT_SRC_COL_LSB = 4;
   localparam int PKT_SRC_ROW_LSB = 6;
   localparam int PKT_VALID_BIT   = 8;
   localparam int PKT_RSP_BIT     = 9;
   localparam int PKT_WRITE_BIT   = 10;
   localparam int PKT_SLVERR_BIT  = 11;
   localparam int PKT_ADDR_LSB    = 12;
   localparam int PKT_DATA_LSB    = 44;

   // Destination coordinates carried in the APB address
   localparam int ADDR_ROW_MSB = 31;
   localparam int ADDR_ROW_LSB = 30;
   localparam int ADDR_COL_MSB = 29;
   localparam int ADDR_COL_LSB = 28;

   // Packed view of a packet, MSB first
   typedef struct packed {
      logic [APB_DATA_W-1:0] data;
      logic [APB_ADDR_W-1:0] addr;
      logic                  slverr;
      logic                  write;
      logic                  response;
      logic                  valid;
      logic [COORD_W-1:0]    src_row;
      logic [COORD_W-1:0]    src_col;
      logic [COORD_W-1:0]    dst_row;
      logic [COORD_W-1:0]    dst_col;
   } apbPacket_t;

endpackage

// File: rtl/ni_packer.sv
// -----------------------------------------------------------------------------
// ni_packer : combinational packet packer/unpacker.
// Ports:
//   valid, response, write, slverr  in   header flags of the outgoing packet
//   dst_row, dst_col, src_row, src_col in coordinates of the outgoing packet
//   addr, data                      in   payload of the outgoing packet
//   pkt                             out  packed outgoing packet
//   raw                             in   raw incoming packet
//   fields                          out  incoming packet split into fields
// -----------------------------------------------------------------------------
module ni_packer
   import pa_noc::*;
(
   input  logic                        valid,
   input  logic                        response,
   input  logic                        write,
   input  logic                        slverr,
   input  logic [COORD_W-1:0]          dst_row,
   input  logic [COORD_W-1:0]          dst_col,
   input  logic [COORD_W-1:0]          src_row,
   input  logic [COORD_W-1:0]          src_col,
   input  logic [APB_ADDR_W-1:0]       addr,
   input  logic [APB_DATA_W-1:0]       data,
   output logic [APB_PACKET_WIDTH-1:0] pkt,
   input  logic [APB_PACKET_WIDTH-1:0] raw,
   output apbPacket_t                  fields
);

   always_comb begin
      pkt                                = '0;
      pkt[PKT_DST_COL_LSB +: COORD_W]    = dst_col;
      pkt[PKT_DST_ROW_LSB +: COORD_W]    = dst_row;
      pkt[PKT_SRC_COL_LSB +: COORD_W]    = src_col;
      pkt[PKT_SRC_ROW_LSB +: COORD_W]    = src_row;
      pkt[PKT_VALID_BIT]                 = valid;
      pkt[PKT_RSP_BIT]                   = response;
      pkt[PKT_WRITE_BIT]                 = write;
      pkt[PKT_SLVERR_BIT]                = slverr;
      pkt[PKT_ADDR_LSB +: APB_ADDR_W]    = addr;
      pkt[PKT_DATA_LSB +: APB_DATA_W]    = data;
   end

   assign fields = apbPacket_t'(raw);

endmodule

// File: rtl/network_interface.sv
// -----------------------------------------------------------------------------
// network_interface : requester-side NI between a local APB requester and the
// router of the same grid node. One APB transfer at a time is turned into a
// single-cycle request packet; the matching response completes the transfer.
//
// Optional feature: define NOC_NI_TIMEOUT_EN to enable the response timeout
// (TIMEOUT_CYCLES WAIT cycles, then completion with o_pslverr=1).
//
// Ports:
//   i_clk, i_arst_n                    clock, async active-low reset
//   i_psel, i_penable, i_pwrite        APB control
//   i_paddr, i_pwdata                  APB address ([31:30] row, [29:28] col) / write data
//   o_pready, o_prdata, o_pslverr      APB completion
//   o_reqPacket                        request packet to router local input
//   i_rspPacket                        packet from router local output
// -----------------------------------------------------------------------------
module network_interface
   import pa_noc::*;
#(
   parameter int GRID_WIDTH     = 4,
   parameter int NODE_ROW       = 0,
   parameter int NODE_COL       = 0,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        i_clk,
   input  logic                        i_arst_n,
   input  logic                        i_psel,
   input  logic                        i_penable,
   input  logic                        i_pwrite,
   input  logic [APB_ADDR_W-1:0]       i_paddr,
   input  logic [APB_DATA_W-1:0]       i_pwdata,
   output logic                        o_pready,
   output logic [APB_DATA_W-1:0]       o_prdata,
   output logic                        o_pslverr,
   output logic [APB_PACKET_WIDTH-1:0] o_reqPacket,
   input  logic [APB_PACKET_WIDTH-1:0] i_rspPacket
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [COORD_W-1:0] MY_ROW = COORD_W'(NODE_ROW);
   localparam logic [COORD_W-1:0] MY_COL = COORD_W'(NODE_COL);

   state_t                        state_q, state_d;
   logic [COORD_W-1:0]            cap_row, cap_col;
   logic [APB_PACKET_WIDTH-1:0]   req_pkt;
   apbPacket_t                    rsp;
   logic                          start, self_addr, accept, timeout;
   logic [COORD_W-1:0]            dst_row, dst_col;

   assign dst_row   = i_paddr[ADDR_ROW_MSB:ADDR_ROW_LSB];
   assign dst_col   = i_paddr[ADDR_COL_MSB:ADDR_COL_LSB];
   assign start     = (state_q == ST_IDLE) && i_psel && i_penable;
   assign self_addr = (dst_row == MY_ROW) && (dst_col == MY_COL);

   // The request is built straight from the APB inputs and registered at the
   // capture edge, so it appears on o_reqPacket exactly during SEND.
   ni_packer u_packer (
      .valid    (1'b1),
      .response (1'b0),
      .write    (i_pwrite),
      .slverr   (1'b0),
      .dst_row  (dst_row),
      .dst_col  (dst_col),
      .src_row  (MY_ROW),
      .src_col  (MY_COL),
      .addr     (i_paddr),
      .data     (i_pwrite ? i_pwdata : '0),
      .pkt      (req_pkt),
      .raw      (i_rspPacket),
      .fields   (rsp)
   );

   assign accept = (state_q == ST_WAIT) && rsp.valid && rsp.response &&
                   (rsp.dst_row == MY_ROW) && (rsp.dst_col == MY_COL) &&
                   (rsp.src_row == cap_row) && (rsp.src_col == cap_col);

   // The router echoes address/write fields we never need to inspect.
   logic unused_rsp;
   assign unused_rsp = ^{rsp.addr, rsp.write};

`ifdef NOC_NI_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] to_cnt;

   // Held at zero outside WAIT, so it is cleared on every entry to WAIT.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n)
         to_cnt <= '0;
      else if (state_q != ST_WAIT)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   // A response accepted in the expiry cycle takes priority.
   assign timeout = (state_q == ST_WAIT) && !accept &&
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   logic unused_cfg;
   assign unused_cfg = (GRID_WIDTH == 0);
`else
   assign timeout = 1'b0;

   logic unused_cfg;
   assign unused_cfg = (GRID_WIDTH == 0) || (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = self_addr ? ST_DONE : ST_SEND;
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: if (accept || timeout) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Destination capture; only needed for response matching.
   always_ff @(posedge i_clk) begin
      if (start) begin
         cap_row <= dst_row;
         cap_col <= dst_col;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_reqPacket <= '0;
         o_prdata    <= '0;
         o_pslverr   <= 1'b0;
      end else begin
         o_reqPacket <= (start && !self_addr) ? req_pkt : '0;
         if (start && self_addr) begin
            o_prdata  <= '0;
            o_pslverr <= 1'b1;
         end else if (accept) begin
            o_prdata  <= rsp.data;
            o_pslverr <= rsp.slverr;
         end else if (timeout) begin
            o_prdata  <= '0;
            o_pslverr <= 1'b1;
         end else if (state_q == ST_DONE) begin
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
         end
      end
   end

   assign o_pready = (state_q == ST_DONE);

endmodule

// File: tb/tb_network_interface.sv
module tb_network_interface;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic [75:0] req_pkt;
   logic [75:0] rsp_pkt = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   network_interface #(
      .GRID_WIDTH     (4),
      .NODE_ROW       (1),
      .NODE_COL       (1),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .i_clk       (clk),
      .i_arst_n    (arst_n),
      .i_psel      (psel),
      .i_penable   (penable),
      .i_pwrite    (pwrite),
      .i_paddr     (paddr),
      .i_pwdata    (pwdata),
      .o_pready    (pready),
      .o_prdata    (prdata),
      .o_pslverr   (pslverr),
      .o_reqPacket (req_pkt),
      .i_rspPacket (rsp_pkt)
   );

   task automatic check_eq(input string tag, input logic [75:0] got, input logic [75:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // APB setup phase then access phase; returns at the negedge of cycle A.
   task automatic apb_start(input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
   endtask

   task automatic apb_end();
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      check_eq("rst_pready",  76'(pready),  76'd0);
      check_eq("rst_prdata",  76'(prdata),  76'd0);
      check_eq("rst_pslverr", 76'(pslverr), 76'd0);
      check_eq("rst_req",     req_pkt,      76'd0);
      @(negedge clk); arst_n = 1'b1;

      // Write 0xDEADBEEF to (1,2)
      apb_start(1'b1, 32'h6000_0010, 32'hDEAD_BEEF);
      @(negedge clk);                                   // A+1
      check_eq("wr_req_pkt",   req_pkt, {32'hDEAD_BEEF, 32'h6000_0010, 12'h556});
      check_eq("wr_req_dst",   76'(req_pkt[3:0]), 76'h6);
      check_eq("wr_req_valid", 76'(req_pkt[8]),   76'd1);
      check_eq("wr_pready_a1", 76'(pready),       76'd0);
      @(negedge clk);                                   // A+2 = R
      check_eq("wr_req_gone",  req_pkt, 76'd0);
      rsp_pkt = {32'h0, 32'h6000_0010, 12'h365};
      @(negedge clk);                                   // R+1
      rsp_pkt = '0;
      check_eq("wr_pready",  76'(pready),  76'd1);
      check_eq("wr_pslverr", 76'(pslverr), 76'd0);
      apb_end();
      @(negedge clk);
      check_eq("wr_pready_drop", 76'(pready), 76'd0);

      // Read from (0,0)
      apb_start(1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
      @(negedge clk);
      check_eq("rd_req_pkt", req_pkt, {32'h0, 32'h0000_0004, 12'h150});
      repeat (3) @(negedge clk);
      check_eq("rd_wait_pready", 76'(pready), 76'd0);
      rsp_pkt = {32'h1234_5678, 32'h0000_0004, 12'h305};
      @(negedge clk);
      rsp_pkt = '0;
      check_eq("rd_pready", 76'(pready), 76'd1);
      check_eq("rd_prdata", 76'(prdata), 76'h1234_5678);
      apb_end();
      @(negedge clk);
      check_eq("rd_prdata_clr", 76'(prdata), 76'd0);

      // Self-addressed access
      apb_start(1'b0, 32'h5000_0000, 32'h0);
      @(negedge clk);
      check_eq("self_pready",  76'(pready),  76'd1);
      check_eq("self_pslverr", 76'(pslverr), 76'd1);
      check_eq("self_prdata",  76'(prdata),  76'd0);
      check_eq("self_no_req",  req_pkt,      76'd0);
      apb_end();
      @(negedge clk);
      check_eq("self_no_req2", req_pkt,      76'd0);

      // Non-matching packets in WAIT, then a matching one with slverr
      apb_start(1'b0, 32'h6000_0010, 32'h0);
      @(negedge clk);                                   // SEND
      @(negedge clk);                                   // WAIT
      rsp_pkt = {32'hBAD0_0001, 32'h0, 12'h305};        // wrong source
      @(negedge clk);
      check_eq("nm_src", 76'(pready), 76'd0);
      rsp_pkt = {32'hBAD0_0002, 32'h0, 12'h165};        // response=0
      @(negedge clk);
      check_eq("nm_rsp", 76'(pready), 76'd0);
      rsp_pkt = {32'hBAD0_0003, 32'h0, 12'h36A};        // other destination
      @(negedge clk);
      check_eq("nm_dst", 76'(pready), 76'd0);
      rsp_pkt = {32'hA5A5_0001, 32'h0, 12'hB65};        // match, slverr=1
      @(negedge clk);
      rsp_pkt = '0;
      check_eq("nm_ok_pready",  76'(pready),  76'd1);
      check_eq("nm_ok_pslverr", 76'(pslverr), 76'd1);
      check_eq("nm_ok_prdata",  76'(prdata),  76'hA5A5_0001);
      apb_end();
      @(negedge clk);

      // Timeout
      apb_start(1'b1, 32'h6000_0010, 32'h0000_0042);
      @(negedge clk);                                   // SEND
`ifdef NOC_NI_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);                                // WAIT cycles 1..8
         check_eq($sformatf("to_wait%0d", i), 76'(pready), 76'd0);
      end
      @(negedge clk);
      check_eq("to_pready",  76'(pready),  76'd1);
      check_eq("to_pslverr", 76'(pslverr), 76'd1);
      check_eq("to_prdata",  76'(prdata),  76'd0);
`else
      repeat (20) @(negedge clk);
      check_eq("noto_hold", 76'(pready), 76'd0);
      rsp_pkt = {32'h0, 32'h0, 12'h365};
      @(negedge clk);
      rsp_pkt = '0;
      check_eq("noto_pready", 76'(pready), 76'd1);
`endif
      apb_end();
      @(negedge clk);

      // Reset during WAIT
      apb_start(1'b1, 32'h6000_0010, 32'h1111_2222);
      @(negedge clk);
      @(negedge clk);                                   // WAIT
      arst_n = 1'b0;
      #1;
      check_eq("mrst_pready",  76'(pready),  76'd0);
      check_eq("mrst_prdata",  76'(prdata),  76'd0);
      check_eq("mrst_pslverr", 76'(pslverr), 76'd0);
      check_eq("mrst_req",     req_pkt,      76'd0);
      apb_end();
      @(negedge clk);
      arst_n = 1'b1;
      rsp_pkt = {32'h0, 32'h6000_0010, 12'h365};        // late response
      @(negedge clk);
      rsp_pkt = '0;
      check_eq("late_pready", 76'(pready), 76'd0);
      @(negedge clk);
      check_eq("late_pready2", 76'(pready), 76'd0);
      // IDLE after reset: a self access completes at A+1
      apb_start(1'b0, 32'h5000_0000, 32'h0);
      @(negedge clk);
      check_eq("post_rst_idle", 76'(pready), 76'd1);
      apb_end();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/network_interface.md
# network_interface

- Requester-side network interface between a local APB requester and the router of the same grid node.
- Accepts one APB transfer at a time and sends it as a single-cycle request packet into the router's local input.
- Waits for the matching response packet from the router's local output, then completes the APB transfer with PREADY, PRDATA and PSLVERR.

## Interface
- GRID_WIDTH, 4, mesh dimension; coordinate width is $clog2(GRID_WIDTH) = 2.
- NODE_ROW, 0, row of this node.
- NODE_COL, 0, column of this node.
- TIMEOUT_CYCLES, 256, response timeout in cycles; used only when NOC_NI_TIMEOUT_EN is defined.
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable.
- i_pwrite  in  1  APB write.
- i_paddr  in  32  APB address; [31:30] is the destination row, [29:28] is the destination column.
- i_pwdata  in  32  APB write data.
- o_pready  out  1  APB ready.
- o_prdata  out  32  APB read data.
- o_pslverr  out  1  APB error.
- o_reqPacket  out  APB_PACKET_WIDTH  request packet to the router's local input.
- i_rspPacket  in  APB_PACKET_WIDTH  packet from the router's local output.

## Operation
- Packet layout (APB_PACKET_WIDTH = 76):
  - [1:0] destination column, [3:2] destination row.
  - [5:4] source column, [7:6] source row.
  - [8] valid, [9] response, [10] write, [11] slverr.
  - [43:12] address, [75:44] data.
- An all-zero packet means idle. Valid=1 guarantees a non-zero packet.
- The router has no backpressure, so a request packet is presented for exactly one cycle.
- FSM states are IDLE, SEND, WAIT and DONE.
- IDLE:
  - On i_psel && i_penable, capture pwrite, paddr and pwdata.
  - If the destination is this node (NODE_ROW, NODE_COL), go to DONE with slverr=1 and prdata=0. No packet is sent.
  - Otherwise go to SEND.
- SEND:
  - o_reqPacket is registered and carries valid=1, response=0, source = this node, and the captured fields.
  - The data field holds pwdata for writes and 0 for reads.
  - Next state is WAIT. o_reqPacket returns to 0 in the following cycle.
- WAIT:
  - Accept i_rspPacket only if all hold: valid=1, response=1, destination = this node, source = captured destination.
  - On accept, latch the data field into o_prdata and the slverr bit into o_pslverr, then go to DONE.
  - All other packets are ignored and dropped.
- DONE:
  - o_pready=1 for one cycle, then return to IDLE.
  - o_prdata and o_pslverr are cleared on the DONE→IDLE transition.
- Packets arriving in IDLE, SEND or DONE are dropped.
- Deasserting i_psel during WAIT is an APB protocol violation. The block keeps waiting and still asserts o_pready.
- Reset values: o_pready=0, o_prdata=0, o_pslverr=0, o_reqPacket=0, state=IDLE, timeout counter=0.
- Reset mid-transfer returns to IDLE. A late response is dropped because the state is IDLE.

## Timing
- Cycle A is the first cycle with i_psel && i_penable in IDLE.
- Request path: o_reqPacket is valid in cycle A+1 only.
- Response path: a response accepted at cycle R gives o_pready=1 at R+1, with o_prdata and o_pslverr valid in that same cycle.
- Minimum round trip to an adjacent node: A+1 send, router registers at A+2, neighbour NI sees it in A+2. Remote turnaround adds to this.
- Self-addressed transfer: o_pready=1 at A+1 with o_pslverr=1.
- i_penable must remain high until o_pready. No new capture occurs before the state returns to IDLE.

## Configuration
- NOC_NI_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without an accepted response, go to DONE with o_pslverr=1 and o_prdata=0.
  - A response in the same cycle as expiry wins.
- NOC_NI_TIMEOUT_EN undefined: no counter; WAIT is held indefinitely until a matching response.

## Structure
- pa_noc holds the shared definitions:
  - APB_PACKET_WIDTH and the field-offset localparams.
  - packed struct apbPacket_t.
  - APB address and data widths.
  - the row/column address-bit positions.
- The FSM state enum stays local to the module.
- One sub-module, ni_packer, is combinational: it packs and unpacks apbPacket_t from the APB fields and coordinates.

## Test plan
- Node (1,1), write 0xDEADBEEF to 0x6000_0010 (destination 1,2):
  - o_reqPacket[3:0]=0x6 and valid=1 for one cycle at A+1.
  - Response injected with slverr=0 → o_pready=1 one cycle later, o_pslverr=0.
- Read 0x0000_0004 (destination 0,0):
  - Response data 0x12345678 arrives at R → o_prdata=0x12345678 and o_pready=1 at R+1.
- Self-addressed access 0x5000_0000 at node (1,1) → no packet sent; o_pready=1 at A+1 with o_pslverr=1.
- Non-matching packets in WAIT → no completion:
  - wrong source;
  - response=0;
  - different destination.
- Timeout with NOC_NI_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response → o_pready=1 with o_pslverr=1 and o_prdata=0 after 8 WAIT cycles.
- Reset asserted during WAIT:
  - All outputs are 0 and the state is IDLE.
  - A response injected after reset release is ignored and o_pready stays 0.
